aha_axi_sif_rd_data_buf: RTL and testbench
==========================================

# aha_axi_sif_rd_data_buf

Parametrised AXI4 read-data return buffer between the SIF read port and the AXI R channel. It tracks multiple outstanding AR bursts with their IDs, buffers SIF read beats in an internal FIFO with backpressure to SIF, and generates RID, RLAST and RRESP per burst. It sits in the SIF bridge, alongside the AR-to-SIF command path, and replaces the single-burst, non-backpressured read capture.

## Interface
- DATA_W, 64: RDATA / SIF_RD_DATA width.
- ID_W, 4: ARID/RID width.
- DEPTH, 32: data FIFO entries; power of 2, ≥2.
- MAX_OUT, 4: outstanding-burst queue entries; power of 2, ≥1.

- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- ARID  in  ID_W  read ID, sampled on AR handshake.
- ARLEN  in  8  burst length − 1, sampled on AR handshake.
- ARVALID  in  1  observed AR valid.
- ARREADY  in  1  observed AR ready (driven elsewhere).
- CMD_FULL  out  1  burst queue full; upstream must gate ARREADY with it.
- ERR_OVF  out  1  sticky: AR handshake dropped because the queue was full.
- RREADY  in  1  AXI R ready.
- RVALID  out  1  AXI R valid.
- RLAST  out  1  last beat of the head burst.
- RID  out  ID_W  ID of the head burst.
- RRESP  out  2  response.
- RDATA  out  DATA_W  read data.
- SIF_RD_DATA  in  DATA_W  SIF read beat.
- SIF_RD_VALID  in  1  SIF beat valid.
- SIF_RD_READY  out  1  data FIFO can accept a beat.
- SIF_RD_ERR  in  1  beat error flag (only with AHA_SIF_RD_ERR_EN).

## Operation
- Burst queue: a FIFO of {ID, LEN}, MAX_OUT deep.
  - Push on ARVALID&ARREADY.
  - If the queue is full and no pop occurs in the same cycle, the entry is dropped and ERR_OVF sets. ERR_OVF clears only on reset.
- Data FIFO: DEPTH entries.
  - Push on SIF_RD_VALID&SIF_RD_READY.
  - SIF_RD_READY = level < DEPTH, computed from the registered level only; it does not look ahead to a same-cycle pop.
- RVALID = data FIFO not empty AND burst queue not empty.
  - Data that arrives before its burst is queued stays buffered, with RVALID low.
- Beat counter: 8 bits, reset 0.
  - RLAST = RVALID & (beat_cnt == head LEN).
- On RVALID&RREADY:
  - Pop the data FIFO.
  - If RLAST: pop the burst queue and set beat_cnt to 0.
  - Otherwise: beat_cnt increments.
- RDATA, RID and RRESP are forced to 0 while RVALID is low.
- RRESP = 2'b00 (OKAY) unless the configuration below applies.
- Levels use $clog2(DEPTH+1) and $clog2(MAX_OUT+1) bits. Pointers wrap modulo the depth.
- Reset mid-burst: all queues, counters and ERR_OVF are cleared. Any partial burst is discarded.

## Timing
- Reset values:
  - RVALID, RLAST, ERR_OVF, CMD_FULL: 0.
  - RDATA, RID, RRESP: 0.
  - SIF_RD_READY: 1.
- Data latency: a beat pushed at edge N appears on RDATA after edge N, if its burst is queued. No combinational SIF→R path.
- A burst queued at edge N is usable from the cycle after edge N. A same-cycle AR and first data beat give RVALID after one edge.
- R handshake: RDATA, RID, RLAST and RVALID hold stable while RVALID&~RREADY. The next beat appears the cycle after the handshake.
- Full data FIFO with a pop: SIF_RD_READY stays 0 that cycle and rises the next cycle.
- Burst queue full with a simultaneous RLAST pop: the AR is accepted, the level is unchanged, and ERR_OVF is not set.
- ARLEN=0: every beat is RLAST.
- ARLEN=255: beat_cnt reaches 255 without wrap, then resets on RLAST.

## Configuration
- AHA_SIF_RD_ERR_EN defined:
  - The SIF_RD_ERR port exists, and data FIFO entries are DATA_W+1 bits wide.
  - A beat stored with err=1 returns RRESP=2'b10 (SLVERR) on that beat only. Other beats return OKAY.
- AHA_SIF_RD_ERR_EN undefined:
  - There is no SIF_RD_ERR port and the FIFO is DATA_W bits wide.
  - RRESP is constant 2'b00.

## Test plan
- Reset, then AR (ID=3, LEN=3) and 4 SIF beats 0xA0..0xA3 with RREADY=1: 4 R beats with RID=3, RLAST only on 0xA3, RRESP=0.
- Two ARs (ID=1, LEN=0) and (ID=2, LEN=1), then 3 beats: beat 1 has RID=1 with RLAST; beats 2–3 have RID=2 with RLAST on the third.
- RREADY=0 while 32 beats are pushed (DATA_W=64, DEPTH=32): SIF_RD_READY drops after the 32nd push. Raising RREADY drains the FIFO in order, and SIF_RD_READY returns 1 one cycle after the first pop.
- Five ARs with MAX_OUT=4 and no data: CMD_FULL=1 after the 4th and ERR_OVF=1 after the 5th. A 5th AR coincident with an RLAST pop does not set ERR_OVF.
- Assert ARESETn low mid-burst after 2 of 4 beats: all outputs return to reset values. A fresh AR (LEN=0) plus one beat yields RLAST on its first beat.
- With AHA_SIF_RD_ERR_EN: 2-beat burst with SIF_RD_ERR=1 on beat 2 → RRESP 00 then 10.

Source files
------------

// File: rtl/aha_axi_sif_rd_data_buf.sv
// ----------------------------------------------------------------------------
// aha_axi_sif_rd_data_buf
//
// AXI4 read-data return buffer that sits between the SIF read port and the
// AXI R channel. It keeps a queue of outstanding AR bursts ({ID, LEN}) and
// buffers SIF read beats in a data FIFO with backpressure to SIF. From these
// it generates RID, RLAST and RRESP for each burst.
//
// Optional feature macro: AHA_SIF_RD_ERR_EN
//   When this macro is defined, the SIF_RD_ERR port exists and each data FIFO
//   entry carries an error bit. A beat that was stored with err=1 is returned
//   with RRESP=SLVERR. When it is undefined, RRESP is always OKAY.
//
// Ports
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   ARID, ARLEN, ARVALID, ARREADY observed AR channel (push to burst queue)
//   CMD_FULL                      burst queue full (upstream gates ARREADY)
//   ERR_OVF                       sticky: an AR was dropped on a full queue
//   RREADY, RVALID, RLAST, RID,
//   RRESP, RDATA                  AXI R channel
//   SIF_RD_DATA, SIF_RD_VALID,
//   SIF_RD_READY, SIF_RD_ERR      SIF read beat input
// ----------------------------------------------------------------------------
module aha_axi_sif_rd_data_buf #(
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   ARID,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    input  logic              ARREADY,
    output logic              CMD_FULL,
    output logic              ERR_OVF,
    input  logic              RREADY,
    output logic              RVALID,
    output logic              RLAST,
    output logic [ID_W-1:0]   RID,
    output logic [1:0]        RRESP,
    output logic [DATA_W-1:0] RDATA,
`ifdef AHA_SIF_RD_ERR_EN
    input  logic              SIF_RD_ERR,
`endif
    input  logic [DATA_W-1:0] SIF_RD_DATA,
    input  logic              SIF_RD_VALID,
    output logic              SIF_RD_READY
);

    localparam int DLVL_W = $clog2(DEPTH + 1);
    localparam int DPTR_W = $clog2(DEPTH);
    localparam int CLVL_W = $clog2(MAX_OUT + 1);
    localparam int CPTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
`ifdef AHA_SIF_RD_ERR_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    // Advance a burst-queue pointer. MAX_OUT may be 1, so the wrap is explicit.
    function automatic logic [CPTR_W-1:0] cptr_inc(input logic [CPTR_W-1:0] p);
        if (p == CPTR_W'(MAX_OUT - 1)) begin
            return {CPTR_W{1'b0}};
        end else begin
            return p + CPTR_W'(1);
        end
    endfunction

    // Data FIFO state
    logic [ENTRY_W-1:0] dmem_r [DEPTH];
    logic [DPTR_W-1:0]  dwr_ptr_r;
    logic [DPTR_W-1:0]  drd_ptr_r;
    logic [DLVL_W-1:0]  dlvl_r;

    // Burst queue state
    logic [ID_W-1:0]    cmem_id_r  [MAX_OUT];
    logic [7:0]         cmem_len_r [MAX_OUT];
    logic [CPTR_W-1:0]  cwr_ptr_r;
    logic [CPTR_W-1:0]  crd_ptr_r;
    logic [CLVL_W-1:0]  clvl_r;

    logic [7:0]         beat_cnt_r;
    logic               err_ovf_r;

    logic               sif_ready_s;
    logic               d_push_s;
    logic               d_pop_s;
    logic               c_full_s;
    logic               ar_hs_s;
    logic               c_push_s;
    logic               c_pop_s;
    logic               ovf_s;
    logic               rvalid_s;
    logic               rlast_s;
    logic [ENTRY_W-1:0] dhead_s;
    logic [ENTRY_W-1:0] entry_s;

`ifdef AHA_SIF_RD_ERR_EN
    assign entry_s = {SIF_RD_ERR, SIF_RD_DATA};
`else
    assign entry_s = SIF_RD_DATA;
`endif

    // Ready depends only on the registered level, never on a same-cycle pop.
    assign sif_ready_s = (dlvl_r < DLVL_W'(DEPTH));
    assign d_push_s    = SIF_RD_VALID & sif_ready_s;
    assign dhead_s     = dmem_r[drd_ptr_r];

    assign c_full_s    = (clvl_r == CLVL_W'(MAX_OUT));
    assign ar_hs_s     = ARVALID & ARREADY;

    // R is offered only when both a beat and its burst are available.
    assign rvalid_s    = (dlvl_r != {DLVL_W{1'b0}}) & (clvl_r != {CLVL_W{1'b0}});
    assign rlast_s     = rvalid_s & (beat_cnt_r == cmem_len_r[crd_ptr_r]);
    assign d_pop_s     = rvalid_s & RREADY;
    assign c_pop_s     = d_pop_s & rlast_s;

    // A full queue still accepts an AR when the head burst retires that cycle.
    assign c_push_s    = ar_hs_s & (~c_full_s | c_pop_s);
    assign ovf_s       = ar_hs_s & c_full_s & ~c_pop_s;

    // Data FIFO storage write (storage needs no reset; outputs are masked by RVALID).
    always_ff @(posedge ACLK) begin
        if (d_push_s) begin
            dmem_r[dwr_ptr_r] <= entry_s;
        end
    end

    // Data FIFO pointers and level.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            dwr_ptr_r <= {DPTR_W{1'b0}};
            drd_ptr_r <= {DPTR_W{1'b0}};
            dlvl_r    <= {DLVL_W{1'b0}};
        end else begin
            if (d_push_s) begin
                dwr_ptr_r <= dwr_ptr_r + DPTR_W'(1);
            end
            if (d_pop_s) begin
                drd_ptr_r <= drd_ptr_r + DPTR_W'(1);
            end
            case ({d_push_s, d_pop_s})
                2'b10:   dlvl_r <= dlvl_r + DLVL_W'(1);
                2'b01:   dlvl_r <= dlvl_r - DLVL_W'(1);
                default: dlvl_r <= dlvl_r;
            endcase
        end
    end

    // Burst queue storage, pointers and level.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                cmem_id_r[i]  <= {ID_W{1'b0}};
                cmem_len_r[i] <= 8'd0;
            end
            cwr_ptr_r <= {CPTR_W{1'b0}};
            crd_ptr_r <= {CPTR_W{1'b0}};
            clvl_r    <= {CLVL_W{1'b0}};
        end else begin
            if (c_push_s) begin
                cmem_id_r[cwr_ptr_r]  <= ARID;
                cmem_len_r[cwr_ptr_r] <= ARLEN;
                cwr_ptr_r             <= cptr_inc(cwr_ptr_r);
            end
            if (c_pop_s) begin
                crd_ptr_r <= cptr_inc(crd_ptr_r);
            end
            case ({c_push_s, c_pop_s})
                2'b10:   clvl_r <= clvl_r + CLVL_W'(1);
                2'b01:   clvl_r <= clvl_r - CLVL_W'(1);
                default: clvl_r <= clvl_r;
            endcase
        end
    end

    // Beat counter within the head burst and sticky overflow flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            beat_cnt_r <= 8'd0;
            err_ovf_r  <= 1'b0;
        end else begin
            if (d_pop_s) begin
                if (rlast_s) begin
                    beat_cnt_r <= 8'd0;
                end else begin
                    beat_cnt_r <= beat_cnt_r + 8'd1;
                end
            end
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end
        end
    end

    // R channel outputs, zeroed while no beat is offered.
    always_comb begin
        RVALID = rvalid_s;
        RLAST  = rlast_s;
        RDATA  = {DATA_W{1'b0}};
        RID    = {ID_W{1'b0}};
        RRESP  = 2'b00;
        if (rvalid_s) begin
            RDATA = dhead_s[DATA_W-1:0];
            RID   = cmem_id_r[crd_ptr_r];
`ifdef AHA_SIF_RD_ERR_EN
            RRESP = dhead_s[DATA_W] ? 2'b10 : 2'b00;
`else
            RRESP = 2'b00;
`endif
        end else begin
            RDATA = {DATA_W{1'b0}};
            RID   = {ID_W{1'b0}};
            RRESP = 2'b00;
        end
    end

    assign CMD_FULL     = c_full_s;
    assign ERR_OVF      = err_ovf_r;
    assign SIF_RD_READY = sif_ready_s;

endmodule

// File: tb/tb_aha_axi_sif_rd_data_buf.sv
// Directed testbench for aha_axi_sif_rd_data_buf (default parameters).
module tb_aha_axi_sif_rd_data_buf;

    logic        ACLK;
    logic        ARESETn;
    logic [3:0]  ARID;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic        CMD_FULL;
    logic        ERR_OVF;
    logic        RREADY;
    logic        RVALID;
    logic        RLAST;
    logic [3:0]  RID;
    logic [1:0]  RRESP;
    logic [63:0] RDATA;
    logic [63:0] SIF_RD_DATA;
    logic        SIF_RD_VALID;
    logic        SIF_RD_READY;
`ifdef AHA_SIF_RD_ERR_EN
    logic        SIF_RD_ERR;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    aha_axi_sif_rd_data_buf dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .ARID         (ARID),
        .ARLEN        (ARLEN),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .CMD_FULL     (CMD_FULL),
        .ERR_OVF      (ERR_OVF),
        .RREADY       (RREADY),
        .RVALID       (RVALID),
        .RLAST        (RLAST),
        .RID          (RID),
        .RRESP        (RRESP),
        .RDATA        (RDATA),
`ifdef AHA_SIF_RD_ERR_EN
        .SIF_RD_ERR   (SIF_RD_ERR),
`endif
        .SIF_RD_DATA  (SIF_RD_DATA),
        .SIF_RD_VALID (SIF_RD_VALID),
        .SIF_RD_READY (SIF_RD_READY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rvalid"}, 64'(RVALID), 64'd0);
        chk({tag, "_rlast"},  64'(RLAST),  64'd0);
        chk({tag, "_ovf"},    64'(ERR_OVF), 64'd0);
        chk({tag, "_full"},   64'(CMD_FULL), 64'd0);
        chk({tag, "_rdata"},  RDATA,        64'd0);
        chk({tag, "_rid"},    64'(RID),     64'd0);
        chk({tag, "_rresp"},  64'(RRESP),   64'd0);
        chk({tag, "_sifrdy"}, 64'(SIF_RD_READY), 64'd1);
    endtask

    task automatic ar(input logic v, input logic [3:0] id, input logic [7:0] len);
        ARVALID = v;
        ARREADY = v;
        ARID    = id;
        ARLEN   = len;
    endtask

    task automatic beat(input logic v, input logic [63:0] d);
        SIF_RD_VALID = v;
        SIF_RD_DATA  = d;
    endtask

    initial begin
        ARESETn = 1'b0;
        RREADY  = 1'b0;
        ar(1'b0, 4'd0, 8'd0);
        beat(1'b0, 64'd0);
`ifdef AHA_SIF_RD_ERR_EN
        SIF_RD_ERR = 1'b0;
`endif
        #12;
        chk_reset_vals("rst");
        #8;
        ARESETn = 1'b1;

        // Single 4-beat burst, ID 3, with RREADY high.
        RREADY = 1'b1;
        ar(1'b1, 4'd3, 8'd3);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 64'hA0 + 64'(i));
            tick();
            ar(1'b0, 4'd0, 8'd0);
            chk("t1_rvalid", 64'(RVALID), 64'd1);
            chk("t1_rdata",  RDATA, 64'hA0 + 64'(i));
            chk("t1_rid",    64'(RID), 64'd3);
            chk("t1_rlast",  64'(RLAST), (i == 3) ? 64'd1 : 64'd0);
            chk("t1_rresp",  64'(RRESP), 64'd0);
        end
        beat(1'b0, 64'd0);
        tick();
        chk("t1_idle", 64'(RVALID), 64'd0);

        // Two queued bursts: (ID1, LEN0) then (ID2, LEN1).
        ar(1'b1, 4'd1, 8'd0);
        tick();
        ar(1'b1, 4'd2, 8'd1);
        tick();
        ar(1'b0, 4'd0, 8'd0);
        beat(1'b1, 64'hB0);
        tick();
        chk("t2_b0_rid",   64'(RID), 64'd1);
        chk("t2_b0_rlast", 64'(RLAST), 64'd1);
        chk("t2_b0_rdata", RDATA, 64'hB0);
        beat(1'b1, 64'hB1);
        tick();
        chk("t2_b1_rid",   64'(RID), 64'd2);
        chk("t2_b1_rlast", 64'(RLAST), 64'd0);
        chk("t2_b1_rdata", RDATA, 64'hB1);
        beat(1'b1, 64'hB2);
        tick();
        chk("t2_b2_rid",   64'(RID), 64'd2);
        chk("t2_b2_rlast", 64'(RLAST), 64'd1);
        chk("t2_b2_rdata", RDATA, 64'hB2);
        beat(1'b0, 64'd0);
        tick();
        chk("t2_idle", 64'(RVALID), 64'd0);

        // Fill the data FIFO with RREADY low, then drain.
        RREADY = 1'b0;
        ar(1'b1, 4'd5, 8'd31);
        tick();
        ar(1'b0, 4'd0, 8'd0);
        for (int i = 0; i < 32; i++) begin
            chk("t3_fill_rdy", 64'(SIF_RD_READY), 64'd1);
            beat(1'b1, 64'hC00 + 64'(i));
            tick();
            chk("t3_hold_rvalid", 64'(RVALID), 64'd1);
            chk("t3_hold_rdata",  RDATA, 64'hC00);
        end
        beat(1'b0, 64'd0);
        chk("t3_full_rdy",   64'(SIF_RD_READY), 64'd0);
        chk("t3_full_rlast", 64'(RLAST), 64'd0);
        RREADY = 1'b1;
        chk("t3_pop_rdy_same", 64'(SIF_RD_READY), 64'd0);
        tick();
        chk("t3_pop_rdy_next", 64'(SIF_RD_READY), 64'd1);
        for (int i = 1; i < 32; i++) begin
            chk("t3_drain_rdata", RDATA, 64'hC00 + 64'(i));
            chk("t3_drain_rlast", 64'(RLAST), (i == 31) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t3_idle", 64'(RVALID), 64'd0);

        // Burst queue overflow with no data.
        RREADY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ar(1'b1, 4'(k), 8'd0);
            tick();
            chk("t4_full", 64'(CMD_FULL), (k == 3) ? 64'd1 : 64'd0);
            chk("t4_ovf0", 64'(ERR_OVF), 64'd0);
        end
        ar(1'b1, 4'd4, 8'd0);
        tick();
        ar(1'b0, 4'd0, 8'd0);
        chk("t4_ovf1",  64'(ERR_OVF), 64'd1);
        chk("t4_full5", 64'(CMD_FULL), 64'd1);
        ARESETn = 1'b0;
        #2;
        chk("t4_rst_ovf",  64'(ERR_OVF), 64'd0);
        chk("t4_rst_full", 64'(CMD_FULL), 64'd0);
        #2;
        ARESETn = 1'b1;

        // Full queue plus a coincident RLAST pop accepts the AR without overflow.
        for (int k = 0; k < 4; k++) begin
            ar(1'b1, 4'd6 + 4'(k), 8'd0);
            tick();
        end
        ar(1'b0, 4'd0, 8'd0);
        beat(1'b1, 64'hD0);
        tick();
        beat(1'b0, 64'd0);
        chk("t4b_rid",   64'(RID), 64'd6);
        chk("t4b_rlast", 64'(RLAST), 64'd1);
        chk("t4b_full",  64'(CMD_FULL), 64'd1);
        ar(1'b1, 4'd10, 8'd0);
        RREADY = 1'b1;
        tick();
        ar(1'b0, 4'd0, 8'd0);
        chk("t4b_noovf",  64'(ERR_OVF), 64'd0);
        chk("t4b_full2",  64'(CMD_FULL), 64'd1);
        chk("t4b_rvalid", 64'(RVALID), 64'd0);
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, 64'hD1 + 64'(k));
            tick();
            chk("t4b_q_rid",   64'(RID), 64'd7 + 64'(k));
            chk("t4b_q_rdata", RDATA, 64'hD1 + 64'(k));
            chk("t4b_q_rlast", 64'(RLAST), 64'd1);
        end
        beat(1'b0, 64'd0);
        tick();
        chk("t4b_idle",  64'(RVALID), 64'd0);
        chk("t4b_empty", 64'(CMD_FULL), 64'd0);

        // Reset in the middle of a 4-beat burst.
        ar(1'b1, 4'd4, 8'd3);
        beat(1'b1, 64'hE0);
        tick();
        ar(1'b0, 4'd0, 8'd0);
        beat(1'b1, 64'hE1);
        tick();
        chk("t5_mid_rdata", RDATA, 64'hE1);
        beat(1'b0, 64'd0);
        ARESETn = 1'b0;
        #2;
        chk_reset_vals("t5_rst");
        #2;
        ARESETn = 1'b1;
        ar(1'b1, 4'd2, 8'd0);
        beat(1'b1, 64'h77);
        tick();
        ar(1'b0, 4'd0, 8'd0);
        beat(1'b0, 64'd0);
        chk("t5_rvalid", 64'(RVALID), 64'd1);
        chk("t5_rlast",  64'(RLAST), 64'd1);
        chk("t5_rid",    64'(RID), 64'd2);
        chk("t5_rdata",  RDATA, 64'h77);
        tick();
        chk("t5_idle", 64'(RVALID), 64'd0);

`ifdef AHA_SIF_RD_ERR_EN
        // Error flag on the second beat of a 2-beat burst.
        ar(1'b1, 4'd1, 8'd1);
        beat(1'b1, 64'hF0);
        SIF_RD_ERR = 1'b0;
        tick();
        ar(1'b0, 4'd0, 8'd0);
        chk("t6_resp0", 64'(RRESP), 64'd0);
        beat(1'b1, 64'hF1);
        SIF_RD_ERR = 1'b1;
        tick();
        beat(1'b0, 64'd0);
        SIF_RD_ERR = 1'b0;
        chk("t6_resp1", 64'(RRESP), 64'd2);
        chk("t6_rlast", 64'(RLAST), 64'd1);
        tick();
        chk("t6_idle", 64'(RVALID), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
